wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between two result sources:
- the ALU result stream;
- the load-return stream from data memory.

ALU results are buffered in a small FIFO. Load returns have priority, since they belong to older instructions. The block drives the writeback select, the destination register, the write data and the write enable.

Parameters:
XLEN, 32, datapath width of results and write data.
FIFO_DEPTH, 2, ALU result buffer depth; power of two, at least 2.
STARVE_LIMIT, 4, consecutive load grants with a waiting ALU entry before an ALU slot is forced (used only under the optional feature).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
alu_valid  in  1  ALU result offered.
alu_ready  out  1  ALU result accepted this cycle when high together with alu_valid.
alu_rd  in  5  ALU destination register.
alu_result  in  XLEN  ALU result value.
ld_valid  in  1  load data offered.
ld_ready  out  1  load data accepted when high together with ld_valid.
ld_rd  in  5  load destination register.
ld_data  in  XLEN  load data value.
reg_write  out  1  register-file write enable.
write_reg  out  5  register-file write address.
write_data  out  XLEN  register-file write data.
memtoreg  out  1  writeback select for the granted source: 0 = load data, 1 = ALU result.
wb_busy  out  1  high while the ALU FIFO holds at least one entry.

Behaviour:
- Reset:
  - FIFO is flushed (count 0, pointers 0).
  - reg_write=0, write_reg=0, write_data=0, memtoreg=0.
  - wb_busy=0, alu_ready=1 from the first cycle after reset, ld_ready=1.
- Reset mid-operation:
  - Buffered ALU entries are discarded.
  - Any handshake sampled in the same cycle as rst is ignored.
- alu_ready = !full.
  - Full is derived from the registered FIFO count.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- ld_ready is 1 in the base build. Load returns are never stalled.
- Grant rule, evaluated each cycle:
  - If ld_valid && ld_ready, grant the load.
  - Otherwise, if the FIFO is non-empty, grant the FIFO head and pop it.
  - Otherwise, no grant.
- All write-port outputs are registered. The grant made in cycle N appears on reg_write/write_reg/write_data/memtoreg in cycle N+1.
  - Load latency: 1 cycle.
  - ALU latency with no contention: accepted at edge N, written at cycle N+2. The FIFO is always traversed; there is no bypass.
- With no grant, reg_write=0. write_reg, write_data and memtoreg hold their previous values.
- A granted entry with rd==0 is consumed but drives reg_write=0, so x0 is never written.
- When an ALU push and a FIFO pop happen in the same cycle, count is unchanged and pointers advance.
- FIFO pointers wrap modulo FIFO_DEPTH. The count field is log2(FIFO_DEPTH)+1 bits wide.
- wb_busy = (count != 0), driven from the registered count. Hazard logic uses it.

Optional Feature:
WB_FAIRNESS_EN
- Defined:
  - A saturating starve counter increments each cycle in which the load is granted while the FIFO is non-empty.
  - The counter clears on any FIFO pop.
  - When the counter reaches STARVE_LIMIT, ld_ready=0 for exactly one cycle, the FIFO head is granted, and the counter clears.
- Not defined:
  - ld_ready is tied to 1 and there is no counter.
  - ALU entries can wait indefinitely under a continuous load stream.

Decomposition:
- Package wb_pkg holds:
  - XLEN_DEF=32 and REG_ADDR_W=5;
  - WB_SEL_LOAD=1'b0 and WB_SEL_ALU=1'b1;
  - a packed struct wb_entry_t {rd, data}.
- One sub-module: wb_alu_fifo.
  - Parameterised synchronous FIFO of wb_entry_t.
  - Ports: push, pop, full, empty, count, head.
- Arbitration logic and output registers stay in the top module.

Test Plan:
1. Reset, then a single ALU result (rd=5, 0x00000011) -> reg_write=1, write_reg=5, write_data=0x11, memtoreg=1 two cycles after acceptance; wb_busy high for exactly one cycle.
2. Load (rd=7, 0xDEADBEEF) presented in the same cycle as an ALU push (rd=3, 0x3) -> load written first (memtoreg=0), ALU entry written the following cycle.
3. Hold ld_valid for 6 cycles while pushing 3 ALU results (FIFO_DEPTH=2) -> alu_ready drops after 2 pushes; the third is accepted only after the drain; no entry is lost or reordered.
4. ALU entry with rd=0 and load with rd=0 -> both consumed, reg_write stays 0, FIFO empties.
5. Assert rst with 2 entries buffered -> next cycle count=0, wb_busy=0, reg_write=0; no buffered entry is written afterwards.
6. WB_FAIRNESS_EN defined, STARVE_LIMIT=4, continuous loads with 1 ALU entry waiting -> ld_ready=0 on the 5th cycle, the ALU entry is written, and loads resume the next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, writeback select encodings and the buffered ALU entry type.
package wb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic WB_SEL_LOAD = 1'b0;
  localparam logic WB_SEL_ALU = 1'b1;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_alu_fifo.sv
// wb_alu_fifo: synchronous FIFO of ALU writeback entries; caller gates push on !full and pop on !empty.
module wb_alu_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  wb_entry_t               din,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output wb_entry_t               head
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  assign count = r_cnt;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign head = r_mem[r_rp];
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wp <= r_wp + AW'(1);
      if (pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push && !rst) r_mem[r_wp] <= din;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between load returns (priority) and buffered ALU results.
// Optional WB_FAIRNESS_EN forces one ALU slot after STARVE_LIMIT load grants that left the FIFO waiting.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_ADDR_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]        alu_result,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [REG_ADDR_W-1:0]  ld_rd,
  input  logic [XLEN-1:0]        ld_data,
  output logic                   reg_write,
  output logic [REG_ADDR_W-1:0]  write_reg,
  output logic [XLEN-1:0]        write_data,
  output logic                   memtoreg,
  output logic                   wb_busy
);
  logic w_full, w_empty, w_push, w_pop, w_ld_gnt;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  wb_entry_t w_din, w_head;
  assign alu_ready = !w_full;
  assign w_push = alu_valid && !w_full;
  assign w_ld_gnt = ld_valid && ld_ready;
  assign w_pop = !w_ld_gnt && !w_empty;
  assign w_din = '{rd: alu_rd, data: alu_result};
  assign wb_busy = w_count != '0;
  wb_alu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .pop(w_pop),
    .din(w_din),
    .full(w_full),
    .empty(w_empty),
    .count(w_count),
    .head(w_head)
  );
`ifdef WB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;
  // Saturation is implicit: at the limit ld_ready drops, so the head is popped and the count clears.
  assign ld_ready = r_starve != SW'(STARVE_LIMIT);
  always_ff @(posedge clk) begin
    if (rst || w_pop) r_starve <= '0;
    else if (w_ld_gnt && !w_empty) r_starve <= r_starve + SW'(1);
  end
`else
  logic w_unused_limit;
  assign w_unused_limit = ^STARVE_LIMIT;
  assign ld_ready = 1'b1;
`endif
  // x0 grants still consume their source but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
      memtoreg <= WB_SEL_LOAD;
    end else begin
      reg_write <= w_ld_gnt ? (ld_rd != '0) : (w_pop && (w_head.rd != '0));
      if (w_ld_gnt || w_pop) begin
        write_reg <= w_ld_gnt ? ld_rd : w_head.rd;
        write_data <= w_ld_gnt ? ld_data : w_head.data;
        memtoreg <= w_ld_gnt ? WB_SEL_LOAD : WB_SEL_ALU;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic clk = 0, rst = 1;
  logic alu_valid = 0, ld_valid = 0;
  logic [4:0] alu_rd = 0, ld_rd = 0;
  logic [31:0] alu_result = 0, ld_data = 0;
  logic alu_ready, ld_ready, reg_write, memtoreg, wb_busy;
  logic [4:0] write_reg;
  logic [31:0] write_data;
  int errs = 0, checks = 0;
  logic [36:0] q[$];
  logic e_we = 0, e_sel = 0;
  logic [4:0] e_reg = 0;
  logic [31:0] e_data = 0;
  int m_starve = 0;

  wb_port_arbiter #(.XLEN(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .memtoreg(memtoreg), .wb_busy(wb_busy)
  );

  always #5 clk = ~clk;

  function automatic logic m_ld_ready();
`ifdef WB_FAIRNESS_EN
    return m_starve != LIMIT;
`else
    return 1'b1;
`endif
  endfunction

  // Reference model: loads win, otherwise the oldest buffered ALU result; pushes only when not full.
  task automatic tick();
    logic gl, gp, push;
    logic [36:0] ent;
    gl = ld_valid && m_ld_ready();
    gp = !gl && q.size() > 0;
    push = alu_valid && q.size() < DEPTH;
    @(posedge clk);
    if (rst) begin
      q.delete();
      e_we = 0; e_reg = 0; e_data = 0; e_sel = 0; m_starve = 0;
    end else begin
      e_we = 0;
      if (gl) begin
        e_we = ld_rd != 0; e_reg = ld_rd; e_data = ld_data; e_sel = 0;
        if (q.size() > 0 && m_starve < LIMIT) m_starve++;
      end else if (gp) begin
        ent = q.pop_front();
        e_we = ent[36:32] != 0; e_reg = ent[36:32]; e_data = ent[31:0]; e_sel = 1;
        m_starve = 0;
      end
      if (push) q.push_back({alu_rd, alu_result});
    end
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0; alu_rd = 0; ld_rd = 0; alu_result = 0; ld_data = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    tick(); tick();
    rst = 0;
    checks++; if (reg_write !== 1'b0) begin errs++; $display("FAIL reset_we got=%0d exp=0", reg_write); end
    checks++; if (write_reg !== 5'd0) begin errs++; $display("FAIL reset_reg got=%0d exp=0", write_reg); end
    checks++; if (write_data !== 32'd0) begin errs++; $display("FAIL reset_data got=%h exp=0", write_data); end
    checks++; if (memtoreg !== 1'b0) begin errs++; $display("FAIL reset_sel got=%0d exp=0", memtoreg); end
    checks++; if (wb_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0d exp=0", wb_busy); end
    checks++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL reset_alu_ready got=%0d exp=1", alu_ready); end
    checks++; if (ld_ready !== 1'b1) begin errs++; $display("FAIL reset_ld_ready got=%0d exp=1", ld_ready); end
  endtask

  task automatic test_single_alu();
    idle(); alu_valid = 1; alu_rd = 5; alu_result = 32'h11;
    tick();
    idle();
    checks++; if (wb_busy !== 1'b1) begin errs++; $display("FAIL single_busy1 got=%0d exp=1", wb_busy); end
    checks++; if (reg_write !== 1'b0) begin errs++; $display("FAIL single_we1 got=%0d exp=0", reg_write); end
    tick();
    checks++; if (reg_write !== 1'b1) begin errs++; $display("FAIL single_we got=%0d exp=1", reg_write); end
    checks++; if (write_reg !== 5'd5) begin errs++; $display("FAIL single_reg got=%0d exp=5", write_reg); end
    checks++; if (write_data !== 32'h11) begin errs++; $display("FAIL single_data got=%h exp=11", write_data); end
    checks++; if (memtoreg !== 1'b1) begin errs++; $display("FAIL single_sel got=%0d exp=1", memtoreg); end
    checks++; if (wb_busy !== 1'b0) begin errs++; $display("FAIL single_busy2 got=%0d exp=0", wb_busy); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errs++; $display("FAIL single_we3 got=%0d exp=0", reg_write); end
    checks++; if (write_data !== 32'h11) begin errs++; $display("FAIL single_hold got=%h exp=11", write_data); end
  endtask

  task automatic test_priority();
    idle();
    ld_valid = 1; ld_rd = 7; ld_data = 32'hDEADBEEF;
    alu_valid = 1; alu_rd = 3; alu_result = 32'h3;
    tick();
    idle();
    checks++; if (reg_write !== 1'b1) begin errs++; $display("FAIL prio_ld_we got=%0d exp=1", reg_write); end
    checks++; if (write_reg !== 5'd7) begin errs++; $display("FAIL prio_ld_reg got=%0d exp=7", write_reg); end
    checks++; if (write_data !== 32'hDEADBEEF) begin errs++; $display("FAIL prio_ld_data got=%h exp=deadbeef", write_data); end
    checks++; if (memtoreg !== 1'b0) begin errs++; $display("FAIL prio_ld_sel got=%0d exp=0", memtoreg); end
    tick();
    checks++; if (write_reg !== 5'd3) begin errs++; $display("FAIL prio_alu_reg got=%0d exp=3", write_reg); end
    checks++; if (write_data !== 32'h3) begin errs++; $display("FAIL prio_alu_data got=%h exp=3", write_data); end
    checks++; if (memtoreg !== 1'b1 || reg_write !== 1'b1) begin errs++; $display("FAIL prio_alu_sel got=%0d/%0d exp=1/1", memtoreg, reg_write); end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      ld_valid = i < 6; ld_rd = 5'(10 + i); ld_data = 32'h1000 + i;
      alu_valid = n_acc < 3; alu_rd = 5'(20 + n_acc); alu_result = 32'h100 + n_acc;
      checks++; if (alu_ready !== (q.size() < DEPTH)) begin errs++; $display("FAIL bp_ready cyc=%0d got=%0d exp=%0d", i, alu_ready, q.size() < DEPTH); end
      if (i >= 2 && i < 6) begin
        checks++; if (alu_ready !== 1'b0) begin errs++; $display("FAIL bp_full cyc=%0d got=%0d exp=0", i, alu_ready); end
      end
      if (alu_valid && alu_ready) n_acc++;
      tick();
      checks++; if ({reg_write, write_reg, write_data, memtoreg} !== {e_we, e_reg, e_data, e_sel}) begin errs++; $display("FAIL bp_out cyc=%0d got=%0d/%0d/%h/%0d exp=%0d/%0d/%h/%0d", i, reg_write, write_reg, write_data, memtoreg, e_we, e_reg, e_data, e_sel); end
    end
    idle();
    checks++; if (n_acc !== 3) begin errs++; $display("FAIL bp_accepted got=%0d exp=3", n_acc); end
    checks++; if (wb_busy !== 1'b0) begin errs++; $display("FAIL bp_drained got=%0d exp=0", wb_busy); end
  endtask

  task automatic test_rd0();
    idle(); alu_valid = 1; alu_rd = 0; alu_result = 32'h55;
    tick();
    idle(); ld_valid = 1; ld_rd = 0; ld_data = 32'h66;
    tick();
    idle();
    checks++; if (reg_write !== 1'b0) begin errs++; $display("FAIL rd0_ld_we got=%0d exp=0", reg_write); end
    checks++; if (wb_busy !== 1'b1) begin errs++; $display("FAIL rd0_busy got=%0d exp=1", wb_busy); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errs++; $display("FAIL rd0_alu_we got=%0d exp=0", reg_write); end
    checks++; if (wb_busy !== 1'b0) begin errs++; $display("FAIL rd0_empty got=%0d exp=0", wb_busy); end
  endtask

  task automatic test_reset_mid();
    idle(); ld_valid = 1; ld_rd = 1; ld_data = 32'hA;
    alu_valid = 1; alu_rd = 9; alu_result = 32'h9;
    tick();
    alu_rd = 10; alu_result = 32'h10;
    tick();
    checks++; if (wb_busy !== 1'b1 || alu_ready !== 1'b0) begin errs++; $display("FAIL mid_full got=%0d/%0d exp=1/0", wb_busy, alu_ready); end
    rst = 1;
    tick();
    rst = 0; idle();
    checks++; if (wb_busy !== 1'b0) begin errs++; $display("FAIL mid_busy got=%0d exp=0", wb_busy); end
    checks++; if (reg_write !== 1'b0) begin errs++; $display("FAIL mid_we got=%0d exp=0", reg_write); end
    checks++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL mid_ready got=%0d exp=1", alu_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (reg_write !== 1'b0) begin errs++; $display("FAIL mid_stale cyc=%0d got=%0d exp=0", i, reg_write); end
    end
  endtask

`ifdef WB_FAIRNESS_EN
  task automatic test_fairness();
    idle(); ld_valid = 1; ld_rd = 1; ld_data = 32'h1;
    alu_valid = 1; alu_rd = 12; alu_result = 32'hA;
    tick();
    alu_valid = 0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ld_ready !== 1'b1) begin errs++; $display("FAIL fair_ready k=%0d got=%0d exp=1", k, ld_ready); end
      ld_rd = 5'(k + 2); ld_data = 32'(k + 2);
      tick();
      checks++; if (memtoreg !== 1'b0) begin errs++; $display("FAIL fair_ld k=%0d got=%0d exp=0", k, memtoreg); end
    end
    checks++; if (ld_ready !== 1'b0) begin errs++; $display("FAIL fair_block got=%0d exp=0", ld_ready); end
    tick();
    checks++; if ({reg_write, memtoreg, write_reg, write_data} !== {1'b1, 1'b1, 5'd12, 32'hA}) begin errs++; $display("FAIL fair_alu got=%0d/%0d/%0d/%h exp=1/1/12/a", reg_write, memtoreg, write_reg, write_data); end
    checks++; if (ld_ready !== 1'b1) begin errs++; $display("FAIL fair_resume got=%0d exp=1", ld_ready); end
    tick();
    checks++; if (memtoreg !== 1'b0 || reg_write !== 1'b1) begin errs++; $display("FAIL fair_ld_after got=%0d/%0d exp=0/1", memtoreg, reg_write); end
    idle();
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 63) == 0;
      ld_valid = $urandom_range(0, 2) == 0; ld_rd = 5'($urandom_range(0, 31)); ld_data = $urandom;
      alu_valid = $urandom_range(0, 3) != 0; alu_rd = 5'($urandom_range(0, 31)); alu_result = $urandom;
      tick();
      checks++; if ({reg_write, write_reg, write_data, memtoreg} !== {e_we, e_reg, e_data, e_sel}) begin errs++; $display("FAIL rnd_out cyc=%0d got=%0d/%0d/%h/%0d exp=%0d/%0d/%h/%0d", i, reg_write, write_reg, write_data, memtoreg, e_we, e_reg, e_data, e_sel); end
      checks++; if ({wb_busy, alu_ready, ld_ready} !== {q.size() != 0, q.size() < DEPTH, m_ld_ready()}) begin errs++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {wb_busy, alu_ready, ld_ready}, {q.size() != 0, q.size() < DEPTH, m_ld_ready()}); end
    end
    rst = 0; idle();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_priority();
    test_backpressure();
    test_rd0();
    test_reset_mid();
`ifdef WB_FAIRNESS_EN
    test_fairness();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
